// File: rtl/rf_portb_arbiter.sv
// Register-file port B arbiter: round-robin between two writeback sources, with a
// starvation-bounded read class (debug reads and a r1..r31 dump sequencer).
module rf_portb_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr0_valid,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  output logic          wr0_ready,
  input  logic          wr1_valid,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_ready,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_rdata,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  output logic          rf_web,
  output logic [AW-1:0] rf_addrb,
  output logic [DW-1:0] rf_dinb,
  input  logic [DW-1:0] rf_doutb
);
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} dump_state_t;

  dump_state_t   r_state;
  logic          r_rr_wr1;
  logic [SW-1:0] r_starve;
  logic [AW-1:0] r_issue_idx;
  logic          r_p1_rd;
  logic          r_p1_dump;
  logic          r_web;
  logic [AW-1:0] r_addrb;
  logic [DW-1:0] r_dinb;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          r_dump_busy;
  logic          r_dump_valid;
  logic [AW-1:0] r_dump_idx;
  logic [DW-1:0] r_dump_data;
  logic          r_dump_done;

  logic w_dump_req;
  logic w_dbg_req;
  logic w_rd_req;
  logic w_any_wr;
  logic w_force;
  logic w_rd_grant;
  logic w_dbg_grant;
  logic w_dump_grant;
  logic w_wr0_grant;
  logic w_wr1_grant;

  // dump_start wins over a same-cycle debug read only while the sequencer is idle
  always_comb begin
    w_dump_req   = (r_state == ISSUE);
    w_dbg_req    = rd_valid && (((r_state == IDLE) && !dump_start) || (r_state == DONE));
    w_rd_req     = w_dump_req || w_dbg_req;
    w_any_wr     = wr0_valid || wr1_valid;
    w_force      = w_rd_req && (r_starve == SW'(STARVE_LIM));
    w_rd_grant   = w_rd_req && (!w_any_wr || w_force);
    w_dbg_grant  = w_rd_grant && !w_dump_req;
    w_dump_grant = w_rd_grant && w_dump_req;
    w_wr0_grant  = !w_rd_grant && wr0_valid && (!wr1_valid || !r_rr_wr1);
    w_wr1_grant  = !w_rd_grant && wr1_valid && (!wr0_valid || r_rr_wr1);
  end

  assign wr0_ready  = w_wr0_grant;
  assign wr1_ready  = w_wr1_grant;
  assign rd_ready   = w_dbg_grant;
  assign rd_rvalid  = r_rvalid;
  assign rd_rdata   = r_rdata;
  assign dump_busy  = r_dump_busy;
  assign dump_valid = r_dump_valid;
  assign dump_idx   = r_dump_idx;
  assign dump_data  = r_dump_data;
  assign dump_done  = r_dump_done;
  assign rf_web     = r_web;
  assign rf_addrb   = r_addrb;
  assign rf_dinb    = r_dinb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_wr1 <= 1'b0;
      r_starve <= '0;
    end else begin
      if (w_wr0_grant)
        r_rr_wr1 <= 1'b1;
      else if (w_wr1_grant)
        r_rr_wr1 <= 1'b0;
      if (w_rd_grant)
        r_starve <= '0;
      else if (w_rd_req && (w_wr0_grant || w_wr1_grant) && (r_starve != SW'(STARVE_LIM)))
        r_starve <= r_starve + 1'b1;
    end
  end

  // Writes to r0 are accepted but never reach the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_web   <= 1'b0;
      r_addrb <= '0;
      r_dinb  <= '0;
    end else if (w_wr0_grant) begin
      r_web   <= (wr0_addr != '0);
      r_addrb <= wr0_addr;
      r_dinb  <= wr0_data;
    end else if (w_wr1_grant) begin
      r_web   <= (wr1_addr != '0);
      r_addrb <= wr1_addr;
      r_dinb  <= wr1_data;
    end else if (w_dbg_grant) begin
      r_web   <= 1'b0;
      r_addrb <= rd_addr;
    end else if (w_dump_grant) begin
      r_web   <= 1'b0;
      r_addrb <= r_issue_idx;
    end else begin
      r_web   <= 1'b0;
    end
  end

  // Read return: rf_doutb is sampled at the end of the cycle its address is on port B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_rd      <= 1'b0;
      r_p1_dump    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_dump_valid <= 1'b0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
    end else begin
      r_p1_rd      <= w_dbg_grant;
      r_p1_dump    <= w_dump_grant;
      r_rvalid     <= r_p1_rd;
      r_dump_valid <= r_p1_dump;
      if (r_p1_rd)
        r_rdata <= rf_doutb;
      if (r_p1_dump) begin
        r_dump_idx  <= r_addrb;
        r_dump_data <= rf_doutb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_issue_idx <= '0;
      r_dump_busy <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_dump_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dump_start) begin
            r_state     <= ISSUE;
            r_issue_idx <= AW'(1);
            r_dump_busy <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_dump_grant) begin
            if (r_issue_idx == '1)
              r_state <= DRAIN;
            else
              r_issue_idx <= r_issue_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (r_dump_valid && (r_dump_idx == '1)) begin
            r_state     <= DONE;
            r_dump_busy <= 1'b0;
            r_dump_done <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_portb_arbiter.sv
// Bench for rf_portb_arbiter: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model of grants, register contents and returns.
module tb_rf_portb_arbiter;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr0_valid = 1'b0, wr1_valid = 1'b0, rd_valid = 1'b0, dump_start = 1'b0;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr0_data = '0, wr1_data = '0;
  logic          wr0_ready, wr1_ready, rd_ready, rd_rvalid;
  logic [DW-1:0] rd_rdata, dump_data, rf_dinb, rf_doutb;
  logic          dump_busy, dump_valid, dump_done, rf_web;
  logic [AW-1:0] dump_idx, rf_addrb;

  rf_portb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done),
    .rf_web(rf_web), .rf_addrb(rf_addrb), .rf_dinb(rf_dinb), .rf_doutb(rf_doutb)
  );

  always #5 clk = ~clk;

  // Register file behind port B
  logic [DW-1:0] mem [32] = '{default: '0};
  always @(posedge clk) if (rf_web) mem[rf_addrb] <= rf_dinb;
  assign rf_doutb = mem[rf_addrb];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic          s_w0v, s_w1v, s_rv, s_ds;
  logic [AW-1:0] s_w0a, s_w1a, s_ra;
  logic [DW-1:0] s_w0d, s_w1d;

  typedef struct { int cyc; int idx; logic [DW-1:0] data; } ev_t;
  logic [DW-1:0] exp_reg [32];
  ev_t           rdq[$];
  ev_t           dq[$];
  bit            m_busy, m_issuing, m_pref1;
  int            m_starve, m_idx, m_done_cyc;
  bit            e_web;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  int n_w0, n_w1, n_web, n_dv, n_busy, n_done;
  bit obs_rd, obs_w1, obs_dv, obs_done;
  int obs_didx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_stim();
    s_w0v = 0; s_w1v = 0; s_rv = 0; s_ds = 0;
    s_w0a = '0; s_w1a = '0; s_ra = '0; s_w0d = '0; s_w1d = '0;
  endtask

  task automatic clr_cnt();
    n_w0 = 0; n_w1 = 0; n_web = 0; n_dv = 0; n_busy = 0; n_done = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_issuing = 0; m_pref1 = 0; m_starve = 0; m_idx = 1; m_done_cyc = -10;
    e_web = 0; e_addr = '0; e_din = '0;
    rdq.delete(); dq.delete();
  endtask

  // One clock cycle: drive stimulus, check DUT against the model, advance the model
  task automatic step();
    int g;
    bit dbg_pend, rd_pend, force_rd, can_start;
    @(negedge clk);
    wr0_valid = s_w0v; wr0_addr = s_w0a; wr0_data = s_w0d;
    wr1_valid = s_w1v; wr1_addr = s_w1a; wr1_data = s_w1d;
    rd_valid = s_rv; rd_addr = s_ra; dump_start = s_ds;
    #1;
    if (cyc == m_done_cyc) m_busy = 0;
    can_start = !m_busy && (cyc != m_done_cyc);
    chk("rf_web", 64'(rf_web), 64'(e_web));
    chk("rf_addrb", 64'(rf_addrb), 64'(e_addr));
    chk("rf_dinb", 64'(rf_dinb), 64'(e_din));
    dbg_pend = s_rv && !m_busy && !(s_ds && can_start);
    rd_pend  = m_issuing || dbg_pend;
    force_rd = rd_pend && (m_starve >= LIM);
    if (rd_pend && (!(s_w0v || s_w1v) || force_rd)) g = m_issuing ? 4 : 3;
    else if (s_w0v && s_w1v) g = m_pref1 ? 2 : 1;
    else if (s_w0v) g = 1;
    else if (s_w1v) g = 2;
    else g = 0;
    chk("wr0_ready", 64'(wr0_ready), 64'(g == 1));
    chk("wr1_ready", 64'(wr1_ready), 64'(g == 2));
    chk("rd_ready", 64'(rd_ready), 64'(g == 3));
    if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
      chk("rd_rvalid", 64'(rd_rvalid), 64'(1));
      chk("rd_rdata", 64'(rd_rdata), 64'(rdq[0].data));
      void'(rdq.pop_front());
    end else begin
      chk("rd_rvalid", 64'(rd_rvalid), 64'(0));
    end
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      chk("dump_valid", 64'(dump_valid), 64'(1));
      chk("dump_idx", 64'(dump_idx), 64'(dq[0].idx));
      chk("dump_data", 64'(dump_data), 64'(dq[0].data));
      void'(dq.pop_front());
    end else begin
      chk("dump_valid", 64'(dump_valid), 64'(0));
    end
    chk("dump_busy", 64'(dump_busy), 64'(m_busy));
    chk("dump_done", 64'(dump_done), 64'(cyc == m_done_cyc));
    obs_rd = rd_ready; obs_w1 = wr1_ready; obs_dv = dump_valid; obs_done = dump_done;
    obs_didx = int'(dump_idx);
    n_w0 += int'(wr0_ready); n_w1 += int'(wr1_ready); n_web += int'(rf_web);
    n_dv += int'(dump_valid); n_busy += int'(dump_busy); n_done += int'(dump_done);
    if (g == 3 || g == 4) m_starve = 0;
    else if (rd_pend && g != 0 && m_starve < LIM) m_starve++;
    case (g)
      1: begin
        m_pref1 = 1; e_web = (s_w0a != 0); e_addr = s_w0a; e_din = s_w0d;
        if (s_w0a != 0) exp_reg[s_w0a] = s_w0d;
      end
      2: begin
        m_pref1 = 0; e_web = (s_w1a != 0); e_addr = s_w1a; e_din = s_w1d;
        if (s_w1a != 0) exp_reg[s_w1a] = s_w1d;
      end
      3: begin
        e_web = 0; e_addr = s_ra;
        rdq.push_back('{cyc: cyc + 2, idx: int'(s_ra), data: exp_reg[s_ra]});
      end
      4: begin
        e_web = 0; e_addr = AW'(m_idx);
        dq.push_back('{cyc: cyc + 2, idx: m_idx, data: exp_reg[m_idx]});
        if (m_idx == 31) begin m_issuing = 0; m_done_cyc = cyc + 3; end
        else m_idx++;
      end
      default: e_web = 0;
    endcase
    if (s_ds && can_start) begin m_busy = 1; m_issuing = 1; m_idx = 1; end
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock
  task automatic do_reset();
    #1;
    rst_n = 0;
    clr_stim();
    wr0_valid = 0; wr1_valid = 0; rd_valid = 0; dump_start = 0;
    #1;
    chk("rst_wr0_ready", 64'(wr0_ready), 64'(0));
    chk("rst_wr1_ready", 64'(wr1_ready), 64'(0));
    chk("rst_rd_ready", 64'(rd_ready), 64'(0));
    chk("rst_rd_rvalid", 64'(rd_rvalid), 64'(0));
    chk("rst_rd_rdata", 64'(rd_rdata), 64'(0));
    chk("rst_dump_busy", 64'(dump_busy), 64'(0));
    chk("rst_dump_valid", 64'(dump_valid), 64'(0));
    chk("rst_dump_idx", 64'(dump_idx), 64'(0));
    chk("rst_dump_data", 64'(dump_data), 64'(0));
    chk("rst_dump_done", 64'(dump_done), 64'(0));
    chk("rst_rf_web", 64'(rf_web), 64'(0));
    chk("rst_rf_addrb", 64'(rf_addrb), 64'(0));
    chk("rst_rf_dinb", 64'(rf_dinb), 64'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int k, first_rd, start_cyc, done_cyc, first_idx;
    for (int i = 0; i < 32; i++) exp_reg[i] = '0;
    clr_stim();
    clr_cnt();
    model_reset();
    do_reset();

    // Write r5 then read it back
    clr_cnt();
    s_w0v = 1; s_w0a = 5; s_w0d = 32'hDEADBEEF; step();
    clr_stim(); s_rv = 1; s_ra = 5; step();
    chk("t1_rd_granted", 64'(obs_rd), 64'(1));
    clr_stim(); repeat (4) step();
    chk("t1_web_cycles", 64'(n_web), 64'(1));

    // Two saturated writers alternate
    clr_cnt();
    s_w0v = 1; s_w0a = 6; s_w1v = 1; s_w1a = 7;
    for (int i = 0; i < 8; i++) begin s_w0d = $urandom; s_w1d = $urandom; step(); end
    chk("alt_wr0_share", 64'(n_w0), 64'(4));
    chk("alt_wr1_share", 64'(n_w1), 64'(4));

    // Debug read against saturated writers is forced through after STARVE_LIM losses
    s_rv = 1; s_ra = 3; first_rd = -1;
    for (k = 0; k < 10 && first_rd < 0; k++) begin
      s_w0d = $urandom; s_w1d = $urandom; step();
      if (obs_rd) begin first_rd = k; s_rv = 0; end
    end
    chk("starve_grant_cycle", 64'(first_rd), 64'(LIM));
    repeat (3) step();
    clr_stim(); repeat (4) step();

    // Write to r0 is accepted but discarded
    s_w1v = 1; s_w1a = 0; s_w1d = 32'h1234; step();
    chk("r0_wr1_ready", 64'(obs_w1), 64'(1));
    clr_stim(); step();
    s_rv = 1; s_ra = 0; step();
    clr_stim(); repeat (4) step();

    // Preload r1..r31 and dump them
    for (int i = 1; i < 32; i++) begin
      s_w0v = 1; s_w0a = AW'(i); s_w0d = 32'(i * 32'h11); step();
    end
    clr_stim(); repeat (2) step();
    clr_cnt();
    start_cyc = cyc; done_cyc = -1;
    s_ds = 1; step(); s_ds = 0;
    for (k = 0; k < 60 && done_cyc < 0; k++) begin
      step();
      if (obs_done) done_cyc = cyc - 1;
    end
    chk("dump_pulses", 64'(n_dv), 64'(31));
    chk("dump_busy_cycles", 64'(n_busy), 64'(33));
    chk("dump_done_offset", 64'(done_cyc - start_cyc), 64'(34));
    repeat (2) step();

    // Reset in the middle of a dump, then restart
    s_ds = 1; step(); s_ds = 0;
    k = 0;
    while (!(obs_dv && obs_didx == 10) && k < 40) begin step(); k++; end
    chk("dump_reached_idx10", 64'(obs_didx), 64'(10));
    do_reset();
    clr_cnt();
    repeat (40) step();
    chk("no_done_after_abort", 64'(n_done), 64'(0));
    s_ds = 1; step(); s_ds = 0;
    k = 0;
    while (!obs_dv && k < 10) begin step(); k++; end
    first_idx = obs_dv ? obs_didx : -1;
    chk("restart_first_idx", 64'(first_idx), 64'(1));
    k = 0;
    while (!obs_done && k < 60) begin step(); k++; end
    chk("restart_done_seen", 64'(obs_done), 64'(1));

    // Random mixed traffic, including dump_start at arbitrary times
    for (int i = 0; i < 800; i++) begin
      s_w0v = ($urandom_range(0, 2) == 0); s_w0a = AW'($urandom_range(0, 7)); s_w0d = $urandom;
      s_w1v = ($urandom_range(0, 2) == 0); s_w1a = AW'($urandom_range(0, 31)); s_w1d = $urandom;
      s_rv  = ($urandom_range(0, 1) == 0); s_ra  = AW'($urandom_range(0, 7));
      s_ds  = ($urandom_range(0, 59) == 0);
      step();
    end
    clr_stim();
    repeat (60) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
